// File: rtl/node_network_interface_if.sv
// Local-port bundle between host logic, node_network_interface and router port 5.
// Latency: n/a (wires only).
// Backpressure: tx_ready toward the host, credits (ci) from the router, rx_ready from the host.
interface node_network_interface_if;
    logic [1:0]  my_cluster;
    logic [1:0]  my_local;
    logic [3:0]  tx_dest;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [19:0] dataout;
    logic        out_valid;
    logic        ci;
    logic [19:0] datain;
    logic        in_valid;
    logic [19:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] read;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [2:0]  err_flags;

    // Seen from the network interface itself.
    modport slave (
        input  my_cluster, my_local, tx_dest, tx_data, tx_valid, ci, datain, in_valid, rx_ready,
        output tx_ready, dataout, out_valid, rx_data, rx_valid, read, tx_count, rx_count, err_flags
    );

    // Seen from host logic and router together.
    modport master (
        output my_cluster, my_local, tx_dest, tx_data, tx_valid, ci, datain, in_valid, rx_ready,
        input  tx_ready, dataout, out_valid, rx_data, rx_valid, read, tx_count, rx_count, err_flags
    );
endinterface

// File: rtl/node_network_interface.sv
// Generic FIFO: wrap-around pointers with an extra lap bit; full/empty from the MSB compare.
// Latency: a pushed word is visible at rdat the cycle after the push edge.
// Backpressure: none internally; callers qualify push/pop against full/empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdat;
    end

    assign rdat  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// Node network interface: packs host requests into flits, injects under router credits, buffers ejected flits.
// Latency: host push to out_valid is 1 cycle; ejected flit to rx_valid is 1 cycle.
// Backpressure: tx_ready drops when the TX FIFO is full; injection stalls at zero credits; RX drops on full (flagged).
module node_network_interface #(
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 4,
    parameter int CREDITS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    node_network_interface_if.slave  nif
);
    typedef struct packed {
        logic [1:0]  cluster;
        logic [1:0]  lcl;
        logic [15:0] payload;
    } flit_t;

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = 1;

    flit_t          tx_head;
    flit_t          tx_flit;
    flit_t          in_flit;
    logic           tx_full;
    logic           tx_empty;
    logic           tx_push;
    logic           send;
    logic [CW-1:0]  credits;
    logic [CW-1:0]  credits_nxt;
    logic           cred_ovf;
    logic           rx_full;
    logic           rx_empty;
    logic           rx_push;
    logic           rx_pop;
    logic           rx_ovf;
    logic           misroute;
    logic [19:0]    rx_head;

    assign tx_flit = {nif.tx_dest, nif.tx_data};
    assign in_flit = nif.datain;

    // Gated by reset so the host never sees a ready while the block is held.
    assign nif.tx_ready = rst && !tx_full;
    assign tx_push      = nif.tx_valid && nif.tx_ready;
    assign send         = !tx_empty && (credits != '0);

    fifo #(.W($bits(flit_t)), .DEPTH(TXQ_DEPTH)) u_txq (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (send),
        .wdat  (tx_flit),
        .rdat  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_comb begin
        credits_nxt = credits;
        cred_ovf    = 1'b0;
        case ({send, nif.ci})
            2'b10: credits_nxt = credits - CRED_ONE;
            2'b01: begin
                if (credits == CRED_MAX) cred_ovf    = 1'b1;
                else                     credits_nxt = credits + CRED_ONE;
            end
            default: credits_nxt = credits;
        endcase
    end

    // A pop frees the head slot this edge, so a full RX FIFO can still take a flit.
    assign rx_pop       = !rx_empty && nif.rx_ready;
    assign rx_push      = nif.in_valid && (!rx_full || rx_pop);
    assign rx_ovf       = nif.in_valid && rx_full && !rx_pop;
    assign misroute     = nif.in_valid &&
                          ({in_flit.cluster, in_flit.lcl} != {nif.my_cluster, nif.my_local});
    assign nif.rx_valid = !rx_empty;
    assign nif.rx_data  = rx_head;

    fifo #(.W($bits(flit_t)), .DEPTH(RXQ_DEPTH)) u_rxq (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdat  (nif.datain),
        .rdat  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits       <= CRED_MAX;
            nif.dataout   <= '0;
            nif.out_valid <= 1'b0;
            nif.read      <= '0;
            nif.tx_count  <= '0;
            nif.rx_count  <= '0;
            nif.err_flags <= '0;
        end else begin
            credits       <= credits_nxt;
            nif.out_valid <= send;
            if (send) begin
                nif.dataout  <= tx_head;
                nif.tx_count <= nif.tx_count + 16'd1;
            end
            if (nif.in_valid) nif.read <= in_flit.payload;
            if (rx_push)      nif.rx_count <= nif.rx_count + 16'd1;
            nif.err_flags <= nif.err_flags | {cred_ovf, misroute, rx_ovf};
        end
    end
endmodule
